csd_seq_conv: RTL and testbench

CSD_SEQ_CONV -- requirements
Module: csd_seq_conv

---
 rtl/csd_pkg.sv | 19 +
 rtl/csd_digit_cell.sv | 22 ++
 rtl/csd_seq_conv.sv | 149 ++++++++++++++
 tb/tb_csd_seq_conv.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/csd_pkg.sv
// Shared digit encodings and FSM state type for the sequential CSD converter.
// Constants and types only; no timing or flow control of its own.
package csd_pkg;

    localparam logic [1:0] ZERO = 2'b00;
    localparam logic [1:0] POS  = 2'b01;
    localparam logic [1:0] NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_nonzero(input logic [1:0] d);
        return d != ZERO;
    endfunction

endpackage

// File: rtl/csd_digit_cell.sv
// One CSD recoding step: digit and next carry from x[i], x[i+1], carry-in. Purely combinational.
// No flow control; the outputs follow the inputs.
module csd_digit_cell
    import csd_pkg::*;
(
    input  logic       x_i,
    input  logic       x_i1,
    input  logic       c,
    output logic [1:0] digit,
    output logic       c_next
);

    always_comb begin
        // carry-out is the majority of the three inputs, i.e. floor((x_i+x_i1+c)/2)
        c_next = (x_i & x_i1) | (x_i & c) | (x_i1 & c);
        digit  = ZERO;
        if (x_i ^ c) begin
            digit = c_next ? NEG : POS;
        end
    end

endmodule

// File: rtl/csd_seq_conv.sv
// Serial binary-to-CSD converter: one digit per cycle, W+1 (unsigned) or W (signed) CONV cycles, then done.
// No backpressure: start is only sampled in IDLE, and results stay readable until the next start.
module csd_seq_conv
    import csd_pkg::*;
#(
    parameter  int W  = 8,
    localparam int AW = $clog2(W + 1),
    localparam int CW = $clog2(W + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          sgn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wbit,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdigit,
    output logic [CW-1:0] nz_count,
    output logic          busy,
    output logic          done
);

    state_t        state;
    state_t        state_nx;
    logic          sgn_q;
    logic          carry;
    logic [AW-1:0] idx;
    logic [AW-1:0] last_idx;
    logic [W-1:0]  xin;
    logic [1:0]    dig [0:W];

    logic [W+1:0]  xext;
    logic [CW-1:0] pos_i;
    logic [CW-1:0] pos_i1;
    logic          x_i;
    logic          x_i1;
    logic [1:0]    cell_digit;
    logic          cell_c_next;
    logic          ext_bit;

    // Operand extended by two bits so x[i+1] is defined for the final step.
    assign ext_bit  = sgn_q & xin[W-1];
    assign xext     = {ext_bit, ext_bit, xin};
    assign pos_i    = CW'(idx);
    assign pos_i1   = CW'(idx) + CW'(1);
    assign x_i      = xext[pos_i];
    assign x_i1     = xext[pos_i1];
    assign last_idx = sgn_q ? AW'(W - 1) : AW'(W);

    csd_digit_cell u_cell (
        .x_i    (x_i),
        .x_i1   (x_i1),
        .c      (carry),
        .digit  (cell_digit),
        .c_next (cell_c_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (idx == last_idx) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sgn_q    <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            nz_count <= '0;
            xin      <= '0;
            for (int k = 0; k <= W; k++) begin
                dig[k] <= ZERO;
            end
        end else begin
            if (we && state != CONV) begin
                for (int k = 0; k < W; k++) begin
                    if (waddr == AW'(k)) begin
                        xin[k] <= wbit;
                    end
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        sgn_q    <= sgn;
                        carry    <= 1'b0;
                        idx      <= '0;
                        nz_count <= '0;
                    end
                end
                CONV: begin
                    carry    <= cell_c_next;
                    idx      <= idx + AW'(1);
                    nz_count <= nz_count + {{(CW-1){1'b0}}, is_nonzero(cell_digit)};
                    for (int k = 0; k <= W; k++) begin
                        if (idx == AW'(k)) begin
                            dig[k] <= cell_digit;
                        end
                    end
                    // Signed results stop at digit W-1; clear the stale top digit once.
                    if (sgn_q && idx == '0) begin
                        dig[W] <= ZERO;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        rdigit = ZERO;
        for (int k = 0; k <= W; k++) begin
            if (raddr == AW'(k)) begin
                rdigit = dig[k];
            end
        end
    end

endmodule

// File: tb/tb_csd_seq_conv.sv
// Directed bench for csd_seq_conv: stimulus queues expected results, a negedge monitor checks them.
module tb_csd_seq_conv;
    import csd_pkg::*;

    localparam int W  = 8;
    localparam int AW = $clog2(W + 1);
    localparam int CW = $clog2(W + 2);
    localparam int DW = 2 * (W + 1);

    localparam int K_RES  = 0;
    localparam int K_SNAP = 1;
    localparam int K_END  = 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          sgn   = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic          wbit  = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [1:0]    rdigit;
    logic [CW-1:0] nz_count;
    logic          busy;
    logic          done;

    csd_seq_conv #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sgn      (sgn),
        .we       (we),
        .waddr    (waddr),
        .wbit     (wbit),
        .raddr    (raddr),
        .rdigit   (rdigit),
        .nz_count (nz_count),
        .busy     (busy),
        .done     (done)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              kind;
        logic [DW-1:0]   dig;
        int              nz;
        int              lat;
        int              issue;
        int              tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [DW-1:0] mk(input int neg_mask, input int pos_mask);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k <= W; k++) begin
            if ((neg_mask >> k) & 1)      r[2*k +: 2] = NEG;
            else if ((pos_mask >> k) & 1) r[2*k +: 2] = POS;
        end
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int tag, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s (case %0d): got %0d, expected %0d", name, tag, act, expv);
        end
    endtask

    task automatic check_state(input exp_t e);
        logic [1:0] ed;
        chk("busy", e.tag, int'(busy), 0);
        chk("nz_count", e.tag, int'(nz_count), e.nz);
        for (int k = 0; k <= W + 2; k++) begin
            raddr = AW'(k);
            #1;
            ed = (k <= W) ? e.dig[2*k +: 2] : 2'b00;
            chk($sformatf("rdigit[%0d]", k), e.tag, int'(rdigit), int'(ed));
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0 && q[0].kind == K_SNAP) begin
                e = q.pop_front();
                chk("done_in_snapshot", e.tag, int'(done), 0);
                check_state(e);
            end else if (done) begin
                if (q.size() != 0 && q[0].kind == K_RES) begin
                    e = q.pop_front();
                    chk("latency", e.tag, cyc - e.issue, e.lat);
                    check_state(e);
                end else begin
                    chk("unexpected_done", -1, 1, 0);
                end
            end else if (q.size() != 0 && q[0].kind == K_RES &&
                         (cyc - q[0].issue) > q[0].lat + 5) begin
                e = q.pop_front();
                chk("done_timeout", e.tag, 0, 1);
            end else if (q.size() != 0 && q[0].kind == K_END) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not reach summary, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [DW-1:0] d, input int nz, input int lat, input int tag);
        exp_t e;
        e.kind  = kind;
        e.dig   = d;
        e.nz    = nz;
        e.lat   = lat;
        e.issue = cyc;
        e.tag   = tag;
        q.push_back(e);
    endtask

    task automatic write_op(input logic [W-1:0] v);
        for (int j = 0; j < W; j++) begin
            we    = 1'b1;
            waddr = AW'(j);
            wbit  = v[j];
            step();
        end
        we = 1'b0;
    endtask

    task automatic run(input int tag, input logic s, input logic [DW-1:0] d, input int nz, input int lat);
        push(K_RES, d, nz, lat, tag);
        start = 1'b1;
        sgn   = s;
        step();
        start = 1'b0;
        repeat (lat + 3) step();
    endtask

    initial begin : stimulus
        repeat (2) step();
        push(K_SNAP, '0, 0, 0, 0);
        step();
        reset = 1'b1;
        step();

        write_op(8'hAB);
        run(1, 1'b0, mk(32'h055, 32'h100), 5, 10);
        run(2, 1'b1, mk(32'h055, 32'h000), 4, 9);

        write_op(8'hFF);
        run(3, 1'b0, mk(32'h001, 32'h100), 2, 10);
        run(4, 1'b1, mk(32'h001, 32'h000), 1, 9);

        write_op(8'h00);
        run(5, 1'b0, mk(0, 0), 0, 10);

        // start and writes during CONV must have no effect on this run or the next
        write_op(8'h07);
        push(K_RES, mk(32'h001, 32'h008), 2, 10, 6);
        start = 1'b1;
        sgn   = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        we    = 1'b1;
        waddr = AW'(5);
        wbit  = 1'b1;
        step();
        waddr = AW'(0);
        wbit  = 1'b0;
        step();
        start = 1'b0;
        we    = 1'b0;
        repeat (10) step();
        run(7, 1'b0, mk(32'h001, 32'h008), 2, 10);

        // reset in the middle of a conversion
        start = 1'b1;
        sgn   = 1'b0;
        step();
        start = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        push(K_SNAP, '0, 0, 0, 8);
        step();
        reset = 1'b1;
        repeat (15) step();
        run(9, 1'b0, mk(0, 0), 0, 10);

        push(K_END, '0, 0, 0, 99);
    end

endmodule
